// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO: shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MULT_EN: multiplies finish in one CALC cycle using a full-width multiplier.
module muldiv_sequencer #(
    parameter int              WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] mag_m;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             valid_op;
    logic             op_signed;
    logic             op_div;
    logic             accept;
    logic             fast_mult;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] fast_prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign valid_op  = (alu_control == 4'b1010) || (alu_control == 4'b1011) ||
                       (alu_control == 4'b1100) || (alu_control == 4'b1101);
    assign op_signed = ~alu_control[0];
    assign op_div    = alu_control[2];
    assign accept    = (state == IDLE) && start && valid_op && !flush;
    assign sign_a    = op_signed & op_a[WIDTH-1];
    assign sign_b    = op_signed & op_b[WIDTH-1];
    assign abs_a     = sign_a ? -op_a : op_a;
    assign abs_b     = sign_b ? -op_b : op_b;
    assign busy      = (state == CALC) || (state == FIX);

`ifdef MULDIV_FAST_MULT_EN
    assign fast_mult = !is_div;
`else
    assign fast_mult = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = CALC;
                CALC:    if (fast_mult || count == '0) state_next = FIX;
                FIX:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // mag_m holds the multiplicand for multiplies and the divisor for divides;
    // acc_lo starts as the multiplier / dividend and shifts out as the op proceeds.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_m} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_m};
        fast_prod = {{WIDTH{1'b0}}, mag_m} * {{WIDTH{1'b0}}, acc_lo};
        prod_fix  = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        fix_hi    = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo    = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (mag_m == '0) begin
                fix_hi = a_raw;
                fix_lo = DIV0_LO;
            end else begin
                fix_hi = neg_r ? -acc_hi : acc_hi;
                fix_lo = neg_q ? -acc_lo : acc_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            a_raw  <= '0;
            mag_m  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!flush) begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            count  <= CW'(WIDTH - 1);
                            is_div <= op_div;
                            neg_q  <= sign_a ^ sign_b;
                            neg_r  <= sign_a;
                            a_raw  <= op_a;
                            mag_m  <= op_div ? abs_b : abs_a;
                            acc_hi <= '0;
                            acc_lo <= op_div ? abs_a : abs_b;
                        end else begin
                            if (hi_we) hi <= wdata;
                            if (lo_we) lo <= wdata;
                        end
                    end
                    CALC: begin
                        if (count != '0) count <= count - 1'b1;
                        if (fast_mult) begin
                            acc_hi <= fast_prod[2*WIDTH-1:WIDTH];
                            acc_lo <= fast_prod[WIDTH-1:0];
                        end else if (is_div) begin
                            acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                    end
                    FIX: begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus randomized ops
// against an arithmetic reference model. Honours MULDIV_FAST_MULT_EN for expected latency.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control),
        .op_a(op_a), .op_b(op_b), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results straight from signed/unsigned integer arithmetic.
    function automatic void model(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = '0;
        el = '0;
        case (ctrl)
            4'b1010: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
            4'b1011: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
            4'b1100: begin
                if (b == 0) begin eh = a; el = 32'hFFFFFFFF; end
                else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
            end
            default: begin
                if (b == 0) begin eh = a; el = 32'hFFFFFFFF; end
                else begin el = a / b; eh = a % b; end
            end
        endcase
    endfunction

    // mode 0: plain; mode 1: start held high with fresh operands while busy;
    // mode 2: hi_we/lo_we raised alongside start and in the first busy cycle.
    task automatic apply_stimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                  input int mode);
        logic [31:0] eh, el, prev_hi, prev_lo;
        int          busy_n, exp_busy;
        bit          seen;
        model(ctrl, a, b, eh, el);
        exp_busy = (FAST && !ctrl[2]) ? 2 : 33;
        prev_hi = hi;
        prev_lo = lo;
        start = 1'b1; alu_control = ctrl; op_a = a; op_b = b;
        if (mode == 2) begin hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom; end
        busy_n = 0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) busy_n++;
            if (mode == 2 && c < 2) begin
                check_output("mt_dropped_hi", hi, prev_hi);
                check_output("mt_dropped_lo", lo, prev_lo);
                if (c == 1) begin hi_we = 1'b0; lo_we = 1'b0; end
            end
            start = (mode == 1) && !seen;
            op_a = $urandom;
            op_b = $urandom;
        end
        check_output("done_seen", 32'(seen), 32'd1);
        check_output("busy_cycles", 32'(busy_n), 32'(exp_busy));
        check_output("busy_in_done", 32'(busy), 32'd0);
        check_output("result_hi", hi, eh);
        check_output("result_lo", lo, el);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    endtask

    initial begin
        logic [31:0] save_hi, save_lo, ra, rb;
        logic [3:0]  rc;
        rst_n = 1'b0; start = 1'b0; alu_control = 4'b0000; op_a = '0; op_b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_hi", hi, 32'd0);
        check_output("reset_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed ops");
        apply_stimulus(4'b1010, 32'hFFFFFFFD, 32'd5, 0);
        check_output("mult_hi_const", hi, 32'hFFFFFFFF);
        check_output("mult_lo_const", lo, 32'hFFFFFFF1);
        apply_stimulus(4'b1101, 32'd100, 32'd7, 0);
        check_output("divu_lo_const", lo, 32'd14);
        check_output("divu_hi_const", hi, 32'd2);
        apply_stimulus(4'b1100, 32'hFFFFFFF9, 32'd2, 1);
        apply_stimulus(4'b1100, 32'd5, 32'd0, 0);
        check_output("div0_lo_const", lo, 32'hFFFFFFFF);
        check_output("div0_hi_const", hi, 32'd5);
        apply_stimulus(4'b1100, 32'h80000000, 32'hFFFFFFFF, 0);
        check_output("divovf_lo_const", lo, 32'h80000000);
        apply_stimulus(4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        apply_stimulus(4'b1101, 32'hDEADBEEF, 32'd0, 2);

        $display("[TB] MTHI/MTLO and invalid start");
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        check_output("mthi_hi", hi, 32'h1234);
        check_output("mthi_done", 32'(done), 32'd0);
        lo_we = 1'b1; wdata = 32'h5678;
        @(negedge clk);
        lo_we = 1'b0;
        check_output("mtlo_lo", lo, 32'h5678);
        check_output("mtlo_hi", hi, 32'h1234);
        start = 1'b1; alu_control = 4'b0010;
        @(negedge clk);
        start = 1'b0;
        check_output("bad_op_busy", 32'(busy), 32'd0);

        $display("[TB] flush mid-op");
        save_hi = hi; save_lo = lo;
        start = 1'b1; alu_control = 4'b1100; op_a = 32'd1000; op_b = 32'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_output("flush_busy", 32'(busy), 32'd0);
        check_output("flush_done", 32'(done), 32'd0);
        check_output("flush_hi", hi, save_hi);
        check_output("flush_lo", lo, save_lo);
        @(negedge clk);
        check_output("flush_no_late_done", 32'(done), 32'd0);
        apply_stimulus(4'b1011, 32'd12345, 32'd6789, 0);

        $display("[TB] reset mid-op");
        start = 1'b1; alu_control = 4'b1010; op_a = 32'h7; op_b = 32'h9;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_hi", hi, 32'd0);
        check_output("rst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_idle_done", 32'(done), 32'd0);

        $display("[TB] randomized ops");
        for (int i = 0; i < 30; i++) begin
            rc = 4'b1010 + 4'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            apply_stimulus(rc, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
